scene_layer_sequencer: RTL and testbench

//  Game-scene controller for the VGA object mux. Tracks game phase (title, play,
//  hit-blink, death, game-over), a lives counter and frame timers. Drives per-layer

---
 rtl/scene_layer_sequencer_if.sv | 22 ++
 rtl/scene_layer_sequencer.sv | 133 +++++++++++++
 tb/tb_scene_layer_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/scene_layer_sequencer_if.sv
// Signal bundle between the game-event sources and the scene/layer sequencer.
// Every i_ signal is a one-cycle pulse sampled on posedge clk with no backpressure, so there is no valid/ready pair.
interface scene_layer_sequencer_if;
  logic       i_startOfFrame;
  logic       i_startKey;
  logic       i_playerHit;
  logic [5:0] o_layerEnable;
  logic [1:0] o_livesLeft;
  logic [2:0] o_sceneState;
  logic       o_gameActive;
  logic [7:0] o_dbgFrameCnt;

  modport master (
    output i_startOfFrame, i_startKey, i_playerHit,
    input  o_layerEnable, o_livesLeft, o_sceneState, o_gameActive, o_dbgFrameCnt
  );

  modport slave (
    input  i_startOfFrame, i_startKey, i_playerHit,
    output o_layerEnable, o_livesLeft, o_sceneState, o_gameActive, o_dbgFrameCnt
  );
endinterface

// File: rtl/scene_layer_sequencer.sv
// Game-scene FSM: tracks phase, lives and frame timers, and produces the per-layer
// draw enables that gate object requests ahead of the VGA mux.
module scene_layer_sequencer #(
  parameter int LIVES_INIT   = 3,
  parameter int HIT_FRAMES   = 64,
  parameter int BLINK_PERIOD = 8,
  parameter int DEATH_FRAMES = 120
) (
  input  logic                    clk,
  input  logic                    reset,
  scene_layer_sequencer_if.slave  bus
);
  localparam int MAX_FRAMES = (HIT_FRAMES > DEATH_FRAMES) ? HIT_FRAMES : DEATH_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam int BLINK_BIT  = $clog2(BLINK_PERIOD);
  localparam logic [CNT_W-1:0] HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
  localparam logic [CNT_W-1:0] DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAY     = 3'd1,
    S_HIT      = 3'd2,
    S_DEATH    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_cnt_nxt;
  logic [1:0]       r_lives, w_lives_nxt;
  logic [5:0]       r_layer, w_layer_nxt;
  logic             r_active, w_active_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_TITLE;
      r_frame_cnt <= '0;
      r_lives     <= 2'd0;
      r_layer     <= 6'b001000;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_cnt_nxt;
      r_lives     <= w_lives_nxt;
      r_layer     <= w_layer_nxt;
      r_active    <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    w_lives_nxt = r_lives;
    case (r_state)
      S_TITLE: begin
        if (bus.i_startKey) begin
          w_state_nxt = S_PLAY;
          w_lives_nxt = 2'(LIVES_INIT);
          w_cnt_nxt   = '0;
        end
      end
      // A hit wins over startKey and over a coincident frame pulse.
      S_PLAY: begin
        if (bus.i_playerHit) begin
          w_cnt_nxt = '0;
          if (r_lives > 2'd1) begin
            w_state_nxt = S_HIT;
            w_lives_nxt = r_lives - 2'd1;
          end else begin
            w_state_nxt = S_DEATH;
            w_lives_nxt = 2'd0;
          end
        end
      end
      S_HIT: begin
        if (bus.i_startOfFrame) begin
          if (r_frame_cnt == HIT_LAST) begin
            w_state_nxt = S_PLAY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      S_DEATH: begin
        if (bus.i_startOfFrame) begin
          if (r_frame_cnt == DEATH_LAST) begin
            w_state_nxt = S_GAMEOVER;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_frame_cnt + CNT_W'(1);
          end
        end
      end
      S_GAMEOVER: begin
        if (bus.i_startKey) begin
          w_state_nxt = S_TITLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_TITLE;
        w_cnt_nxt   = '0;
        w_lives_nxt = 2'd0;
      end
    endcase
  end

  // Output registers are loaded from the next-state values so they line up with r_state.
  always_comb begin
    w_layer_nxt  = 6'b001000;
    w_active_nxt = 1'b0;
    case (w_state_nxt)
      S_TITLE:    w_layer_nxt = 6'b001000;
      S_PLAY: begin
        w_layer_nxt  = 6'b011111;
        w_active_nxt = 1'b1;
      end
      S_HIT: begin
        w_layer_nxt  = {1'b0, ~w_cnt_nxt[BLINK_BIT], 4'b1111};
        w_active_nxt = 1'b1;
      end
      S_DEATH:    w_layer_nxt = 6'b101100;
      S_GAMEOVER: w_layer_nxt = 6'b100000;
      default:    w_layer_nxt = 6'b001000;
    endcase
  end

  assign bus.o_layerEnable = r_layer;
  assign bus.o_livesLeft   = r_lives;
  assign bus.o_sceneState  = r_state;
  assign bus.o_gameActive  = r_active;
  assign bus.o_dbgFrameCnt = 8'(r_frame_cnt);
endmodule

// File: tb/tb_scene_layer_sequencer.sv
// Bench for scene_layer_sequencer: vector table, directed multi-cycle scenarios,
// then random pulses checked against a phase/lives/frames model.
module tb_scene_layer_sequencer;
  localparam int HIT_FRAMES   = 64;
  localparam int BLINK_PERIOD = 8;
  localparam int DEATH_FRAMES = 120;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  scene_layer_sequencer_if bus ();

  scene_layer_sequencer #(
    .LIVES_INIT(3), .HIT_FRAMES(HIT_FRAMES),
    .BLINK_PERIOD(BLINK_PERIOD), .DEATH_FRAMES(DEATH_FRAMES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_phase;   // 0 title, 1 play, 2 hit, 3 death, 4 game over
  int m_lives;
  int m_frames;

  task automatic model_reset();
    m_phase = 0; m_lives = 0; m_frames = 0;
  endtask

  task automatic model_step(input bit sof, input bit key, input bit hit);
    if (m_phase == 0) begin
      if (key) begin m_phase = 1; m_lives = 3; m_frames = 0; end
    end else if (m_phase == 1) begin
      if (hit) begin
        m_frames = 0;
        if (m_lives > 1) begin m_lives = m_lives - 1; m_phase = 2; end
        else begin m_lives = 0; m_phase = 3; end
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (sof) begin
        m_frames = m_frames + 1;
        if (m_phase == 2 && m_frames == HIT_FRAMES) begin m_phase = 1; m_frames = 0; end
        if (m_phase == 3 && m_frames == DEATH_FRAMES) begin m_phase = 4; m_frames = 0; end
      end
    end else begin
      if (key) begin m_phase = 0; m_frames = 0; end
    end
  endtask

  function automatic int model_layer();
    case (m_phase)
      0: return 'b001000;
      1: return 'b011111;
      2: return ((m_frames / BLINK_PERIOD) % 2 == 0) ? 'b011111 : 'b001111;
      3: return 'b101100;
      default: return 'b100000;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".state"},  int'(bus.o_sceneState),  m_phase);
    chk({tag, ".lives"},  int'(bus.o_livesLeft),   m_lives);
    chk({tag, ".layer"},  int'(bus.o_layerEnable), model_layer());
    chk({tag, ".active"}, int'(bus.o_gameActive),  (m_phase == 1 || m_phase == 2) ? 1 : 0);
    chk({tag, ".frames"}, int'(bus.o_dbgFrameCnt), m_frames);
  endtask

  // ---------------- drivers ----------------
  task automatic cyc(input bit sof, input bit key, input bit hit);
    @(negedge clk);
    bus.i_startOfFrame = sof;
    bus.i_startKey     = key;
    bus.i_playerHit    = hit;
    @(posedge clk);
    #1;
    bus.i_startOfFrame = 1'b0;
    bus.i_startKey     = 1'b0;
    bus.i_playerHit    = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("reset.state", int'(bus.o_sceneState),  0);
    chk("reset.layer", int'(bus.o_layerEnable), 'b001000);
    chk("reset.lives", int'(bus.o_livesLeft),   0);
    chk("reset.active", int'(bus.o_gameActive), 0);
    chk("reset.frames", int'(bus.o_dbgFrameCnt), 0);
  endtask

  typedef struct {
    bit         sof, key, hit;
    int         exp_state;
    int         exp_lives;
    logic [5:0] exp_layer;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bus.i_startOfFrame = 1'b0;
    bus.i_startKey     = 1'b0;
    bus.i_playerHit    = 1'b0;

    // sof key hit -> state lives layer (one edge per row, starting from reset)
    vecs[0] = '{1'b0, 1'b0, 1'b1, 0, 0, 6'b001000};  // hit in TITLE ignored
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1, 3, 6'b011111};  // start game
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1, 3, 6'b011111};  // key/frame in PLAY ignored
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2, 2, 6'b011111};  // hit beats key
    vecs[4] = '{1'b0, 1'b0, 1'b1, 2, 2, 6'b011111};  // invulnerable
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2, 2, 6'b011111};  // frame 1, hit ignored
    vecs[6] = '{1'b0, 1'b1, 1'b0, 2, 2, 6'b011111};  // key in HIT ignored
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2, 2, 6'b011111};  // frame 2

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].sof, vecs[i].key, vecs[i].hit);
      chk($sformatf("vec%0d.state", i), int'(bus.o_sceneState),  vecs[i].exp_state);
      chk($sformatf("vec%0d.lives", i), int'(bus.o_livesLeft),   vecs[i].exp_lives);
      chk($sformatf("vec%0d.layer", i), int'(bus.o_layerEnable), int'(vecs[i].exp_layer));
    end

    // Blink pattern across a full invulnerable window, with a hit mid-window.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("blink.enter", int'(bus.o_sceneState), 2);
    for (int k = 1; k <= HIT_FRAMES; k++) begin
      cyc(1'b1, 1'b0, (k == 20));
      if (k < HIT_FRAMES) begin
        chk($sformatf("blink.smiley%0d", k), int'(bus.o_layerEnable[4]), ((k / 8) % 2 == 0) ? 1 : 0);
        chk($sformatf("blink.state%0d", k), int'(bus.o_sceneState), 2);
      end
    end
    chk("blink.exit_state", int'(bus.o_sceneState),  1);
    chk("blink.exit_layer", int'(bus.o_layerEnable), 'b011111);
    chk("blink.exit_lives", int'(bus.o_livesLeft),   2);

    // Hit coincident with a frame pulse: that pulse is not counted.
    cyc(1'b1, 1'b0, 1'b1);
    chk("coinc.state",  int'(bus.o_sceneState),  2);
    chk("coinc.frames", int'(bus.o_dbgFrameCnt), 0);
    chk("coinc.lives",  int'(bus.o_livesLeft),   1);
    frames(HIT_FRAMES - 1);
    chk("coinc.still_hit", int'(bus.o_sceneState), 2);
    frames(1);
    chk("coinc.exit", int'(bus.o_sceneState), 1);

    // Last life, death overlay, then reset mid-death.
    cyc(1'b0, 1'b1, 1'b1);
    chk("death.state",  int'(bus.o_sceneState),  3);
    chk("death.layer",  int'(bus.o_layerEnable), 'b101100);
    chk("death.lives",  int'(bus.o_livesLeft),   0);
    chk("death.active", int'(bus.o_gameActive),  0);
    frames(50);
    chk("death.frames50", int'(bus.o_dbgFrameCnt), 50);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    chk("midreset.state",  int'(bus.o_sceneState),  0);
    chk("midreset.frames", int'(bus.o_dbgFrameCnt), 0);
    chk("midreset.lives",  int'(bus.o_livesLeft),   0);
    chk("midreset.layer",  int'(bus.o_layerEnable), 'b001000);

    // Full game to GAMEOVER and back to TITLE.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    frames(HIT_FRAMES);
    cyc(1'b0, 1'b0, 1'b1);
    chk("game.lives1", int'(bus.o_livesLeft), 1);
    frames(HIT_FRAMES);
    cyc(1'b0, 1'b0, 1'b1);
    chk("game.death", int'(bus.o_sceneState), 3);
    frames(DEATH_FRAMES - 1);
    chk("game.still_death", int'(bus.o_sceneState), 3);
    cyc(1'b1, 1'b0, 1'b1);
    chk("game.over_state", int'(bus.o_sceneState),  4);
    chk("game.over_layer", int'(bus.o_layerEnable), 'b100000);
    cyc(1'b0, 1'b1, 1'b0);
    chk("game.title_state", int'(bus.o_sceneState),  0);
    chk("game.title_layer", int'(bus.o_layerEnable), 'b001000);

    // Random pulses against the model, with occasional resets.
    do_reset();
    model_reset();
    for (int n = 0; n < 8000; n++) begin
      bit sof, key, hit;
      sof = ($urandom_range(0, 2) == 0);
      key = ($urandom_range(0, 15) == 0);
      hit = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        cyc(sof, key, hit);
        reset = 1'b0;
        model_reset();
      end else begin
        cyc(sof, key, hit);
        model_step(sof, key, hit);
      end
      chk_model($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
